// File: rtl/solver_scheduler.sv
// Round-robin scheduler that shares one expression-solver datapath between N_REQ
// requesters, with a per-service timeout and abort signalling.
module solver_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] x_in,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic [DATA_W-1:0]       result,
    output logic                    busy,
    output logic                    sol_start,
    output logic [DATA_W-1:0]       sol_x,
    output logic                    sol_clr,
    input  logic                    sol_completed,
    input  logic [DATA_W-1:0]       sol_result
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic [CNT_W-1:0] cnt;

    // Round-robin search starting just after the previous winner, with wrap.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = last;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % 32'(N_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            grant  <= '0;
            result <= '0;
            sol_x  <= '0;
            cnt    <= '0;
            last   <= LAST_RST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= N_REQ'(1) << pick;
                        sol_x <= x_in[int'(pick)*DATA_W +: DATA_W];
                        last  <= pick;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sol_completed) begin
                        result <= sol_result;
                        state  <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_ABORT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so reset silences them without a clock.
    assign busy      = (state != S_IDLE);
    assign sol_start = (state == S_ISSUE);
    assign sol_clr   = (state == S_DONE) || (state == S_ABORT);
    assign err       = (state == S_ABORT);
    assign done      = sol_clr ? grant : '0;

endmodule

// File: tb/tb_solver_scheduler.sv
// Bench for solver_scheduler: directed scenarios then randomized traffic, all
// checked against a transaction-level model of service timing and arbitration.
module tb_solver_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           err;
    logic [W-1:0]   result;
    logic           busy;
    logic           sol_start;
    logic [W-1:0]   sol_x;
    logic           sol_clr;
    logic           sol_completed;
    logic [W-1:0]   sol_result;

    always #5 clk = ~clk;

    solver_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .grant(grant), .done(done),
        .err(err), .result(result), .busy(busy), .sol_start(sol_start),
        .sol_x(sol_x), .sol_clr(sol_clr), .sol_completed(sol_completed),
        .sol_result(sol_result)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [N-1:0]   req_s;
    logic [N*W-1:0] x_s;
    int             next_d;
    logic [W-1:0]   next_res;
    bit             rand_mode;
    bit             in_reset;

    // One service in flight: issue cycle m_s, final (done/abort) cycle m_e.
    bit           m_active;
    int           m_s, m_e, m_d, m_w, m_last;
    bit           m_abort;
    logic [W-1:0] m_x, m_res, m_result;

    int           gq[$];
    int           n_start, n_done, n_err;
    int           start_cyc, done_cyc;
    logic [N-1:0] done_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_last   = N - 1;
        m_x      = '0;
        m_result = '0;
    endtask

    task automatic cycle();
        logic [N-1:0] eg, ed;
        logic         ebusy, estart, eclr, eerr;
        bit           idle_now;
        @(negedge clk);
        cyc++;
        idle_now = !m_active;
        eg = '0; ed = '0; ebusy = 0; estart = 0; eclr = 0; eerr = 0;
        if (m_active) begin
            eg     = N'(1) << m_w;
            ebusy  = 1;
            estart = (cyc == m_s);
            if (cyc == m_e) begin
                ed   = eg;
                eclr = 1;
                eerr = m_abort;
                if (!m_abort) m_result = m_res;
            end
            if (cyc == m_s) gq.push_back(int'(grant));
        end
        chk("grant", grant, eg);
        chk("done", done, ed);
        chk("err", err, eerr);
        chk("busy", busy, ebusy);
        chk("sol_start", sol_start, estart);
        chk("sol_clr", sol_clr, eclr);
        chk("sol_x", sol_x, m_x);
        chk("result", result, m_result);
        if (sol_start) begin n_start++; start_cyc = cyc; end
        if (done != '0) begin n_done++; done_cyc = cyc; done_val = done; end
        if (err) n_err++;
        if (m_active && cyc == m_e) m_active = 0;

        if (rand_mode) begin
            req_s &= ~ed;
            for (int i = 0; i < N; i++)
                if (!req_s[i] && $urandom_range(0, 3) == 0) req_s[i] = 1'b1;
            if (m_active && cyc > m_s && $urandom_range(0, 15) == 0) req_s[m_w] = 1'b0;
            for (int i = 0; i < N; i++) x_s[i*W +: W] = W'($urandom);
        end
        req  = req_s;
        x_in = x_s;
        sol_completed = m_active && (m_d != 0) && (cyc >= m_s + m_d);
        sol_result    = sol_completed ? m_res : W'($urandom);

        if (idle_now && !in_reset && req_s != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (req_s[(m_last + k) % N]) begin
                    m_w = (m_last + k) % N;
                    break;
                end
            end
            m_last   = m_w;
            m_active = 1;
            m_s      = cyc + 1;
            m_x      = x_s[m_w*W +: W];
            m_d      = next_d;
            m_res    = next_res;
            m_abort  = (m_d == 0);
            m_e      = m_abort ? m_s + TO + 1 : m_s + m_d + 1;
            if (rand_mode) begin
                next_d   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
                next_res = W'($urandom);
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (m_active && k < max);
    endtask

    initial begin
        int exp22[5] = '{1, 2, 4, 8, 1};
        int nd, ne, ns;

        rst = 1'b1;
        req_s = '0; x_s = '0; req = '0; x_in = '0;
        sol_completed = 1'b0; sol_result = '0;
        next_d = 3; next_res = '0; rand_mode = 0; in_reset = 1;
        n_start = 0; n_done = 0; n_err = 0; start_cyc = 0; done_cyc = 0; done_val = '0;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        in_reset = 0;

        // Contention from reset: order starts at index 0.
        for (int i = 0; i < N; i++) x_s[i*W +: W] = W'(8'h10 + i);
        gq.delete();
        req_s = 4'b1111;
        repeat (5) run_until_idle(40);
        req_s = '0;
        chk("r22_count", gq.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("r22_order", (i < gq.size()) ? gq[i] : -1, exp22[i]);
        cycle();

        // Single request, completion 6 cycles after start.
        x_s[0 +: W] = 8'd5;
        next_d = 6; next_res = 8'd42;
        ns = n_start; nd = n_done; ne = n_err;
        req_s = 4'b0001;
        run_until_idle(40);
        req_s = '0;
        chk("r21_starts", n_start - ns, 1);
        chk("r21_dones", n_done - nd, 1);
        chk("r21_done_val", done_val, 4'b0001);
        chk("r21_latency", done_cyc - start_cyc, 7);
        chk("r21_result", result, 8'd42);
        chk("r21_err", n_err - ne, 0);
        cycle();

        // Timeout: solver never completes.
        next_d = 0; next_res = 8'hEE;
        ne = n_err;
        req_s = 4'b0010;
        run_until_idle(40);
        req_s = '0;
        chk("r23_latency", done_cyc - start_cyc, 17);
        chk("r23_err", n_err - ne, 1);
        chk("r23_result", result, 8'd42);
        cycle();

        // Completion in the last WAIT cycle beats the timeout.
        next_d = TO; next_res = 8'h99;
        ne = n_err;
        req_s = 4'b1000;
        run_until_idle(40);
        req_s = '0;
        chk("tlast_latency", done_cyc - start_cyc, 17);
        chk("tlast_err", n_err - ne, 0);
        chk("tlast_result", result, 8'h99);
        cycle();

        // Requester drops req during WAIT; operand changes are ignored.
        next_d = 8; next_res = 8'h77;
        req_s = 4'b0100;
        x_s[2*W +: W] = 8'h3C;
        repeat (3) cycle();
        req_s = '0;
        x_s[2*W +: W] = 8'hC3;
        run_until_idle(40);
        chk("r24_done_val", done_val, 4'b0100);
        chk("r24_result", result, 8'h77);
        cycle();

        // Reset in the middle of a service.
        next_d = 10; next_res = 8'h55;
        req_s = 4'b0001;
        repeat (4) cycle();
        nd = n_done;
        #2 rst = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", sol_start, 0);
        chk("rst_sol_x", sol_x, 0);
        chk("rst_clr", sol_clr, 0);
        model_reset();
        in_reset = 1;
        req_s = '0;
        repeat (3) cycle();
        rst = 1'b1;
        in_reset = 0;
        chk("r25_no_done", n_done - nd, 0);
        gq.delete();
        next_d = 2; next_res = 8'hA5;
        req_s = 4'b0100;
        run_until_idle(40);
        req_s = '0;
        chk("r25_grant", (gq.size() > 0) ? gq[0] : -1, 4);
        chk("r25_latency", done_cyc - start_cyc, 3);
        cycle();

        // Wrap-around from last=3.
        next_d = 1; next_res = 8'h11;
        req_s = 4'b1000;
        run_until_idle(40);
        req_s = 4'b1001;
        gq.delete();
        run_until_idle(40);
        run_until_idle(40);
        req_s = '0;
        chk("r26_first", (gq.size() > 0) ? gq[0] : -1, 1);
        chk("r26_second", (gq.size() > 1) ? gq[1] : -1, 8);
        cycle();

        // Randomized traffic.
        rand_mode = 1;
        next_d = 5; next_res = W'($urandom);
        repeat (600) cycle();
        rand_mode = 0;
        req_s = '0;
        run_until_idle(40);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/solver_scheduler.md
SOLVER_SCHEDULER -- requirements
Module: solver_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one expression-solver datapath (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles in WAIT before abort (>=2).
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester service request, held high until its done pulse.
- x_in  in  N_REQ*DATA_W  packed operands; requester i at bits [i*DATA_W +: DATA_W].
- grant  out  N_REQ  one-hot; the requester currently being served.
- done  out  N_REQ  one-cycle pulse to the served requester at end of service.
- err  out  1  one-cycle pulse coincident with done when service was aborted.
- result  out  DATA_W  last captured solver result.
- busy  out  1  high in every state except IDLE.
- sol_start  out  1  start strobe to the solver control.
- sol_x  out  DATA_W  operand to the solver datapath.
- sol_clr  out  1  one-cycle clear returning the solver control to its initial state.
- sol_completed  in  1  solver completion flag; stays high until cleared.
- sol_result  in  DATA_W  solver result, valid while sol_completed is high.

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT, DONE, ABORT.
REQ-006 IDLE: if any req bit is high, pick the winner round-robin, searching from index (last+1) mod N_REQ upward with wrap; latch its x_in slice into sol_x; set grant one-hot; update last to the winner; go to ISSUE. If no req bit is high, stay in IDLE.
REQ-007 ISSUE: sol_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
REQ-008 WAIT: sol_start=0. Sample sol_completed only in this state.
- If sol_completed=1: capture sol_result into result; go to DONE.
- Else if counter==TIMEOUT-1: go to ABORT.
- Else: increment the counter.
REQ-009 DONE: done[winner]=1, err=0, sol_clr=1, all for this cycle only; go to IDLE; grant returns to 0 on entering IDLE.
REQ-010 ABORT: done[winner]=1, err=1, sol_clr=1, all for this cycle only; result unchanged; go to IDLE.
REQ-011 Latency: req high at edge k in IDLE -> grant and sol_start high in cycle k+1; with sol_completed first high in WAIT cycle w, done pulses in cycle w+1.
REQ-012 The round-robin pointer last SHALL reset to N_REQ-1, so the first search starts at index 0.
REQ-013 grant, sol_x and the winner index SHALL stay constant from ISSUE through DONE/ABORT.
- Changes on req or x_in during service are ignored.
- A served requester that drops req mid-service still receives its done pulse.
REQ-014 New requests arriving during service SHALL only be arbitrated in the next IDLE cycle; at most one service is in flight at a time.
REQ-015 Between consecutive services the block SHALL spend exactly one cycle in IDLE.
REQ-016 The same requester SHALL NOT be granted twice in a row while another requester has req high.
REQ-017 done, err, sol_start and sol_clr SHALL never be high in the same cycle as another service's grant change.

Reset
REQ-018 rst low SHALL asynchronously force:
- state=IDLE, grant=0, done=0, err=0, result=0, busy=0;
- sol_start=0, sol_x=0, sol_clr=0;
- timeout counter=0, last=N_REQ-1.
REQ-019 Reset asserted mid-service SHALL abandon that service with no done pulse.
REQ-020 After reset deasserts, the first req SHALL be arbitrated in the first IDLE cycle with the sequence restarting at index 0.

Verification
REQ-021 Single request:
- Stimulus: req=0001, x_in[0]=5, solver asserts sol_completed 6 cycles after sol_start with sol_result=42.
- Required: grant=0001 one cycle after req; one sol_start pulse; done=0001 and sol_clr high together; result=42; err=0.
REQ-022 Contention:
- Stimulus: req=1111 held continuously.
- Required: grants in order 0001, 0010, 0100, 1000, 0001; each grant preceded by one IDLE cycle.
REQ-023 Timeout:
- Stimulus: sol_completed never asserts, TIMEOUT=16.
- Required: done and err pulse 17 cycles after sol_start; sol_clr pulses; result keeps its previous value.
REQ-024 Request drop:
- Stimulus: the granted requester lowers req during WAIT.
- Required: service completes normally; done pulses to that requester.
REQ-025 Reset mid-service:
- Stimulus: rst low during WAIT.
- Required: all outputs 0 immediately without waiting for clk; no done pulse; after release, req=0100 is granted normally.
REQ-026 Wrap-around:
- Stimulus: last=3 with req=1001.
- Required: grant=0001 (index 0), then grant=1000.
